// File: rtl/lsu_req_queue.sv
// Load/store request queue: a circular FIFO of core requests feeding a single-outstanding
// bus master that aligns, replicates and extends data and returns one response per request.
module lsu_req_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [31:0]            req_data,
    input  logic [2:0]             req_type_m,
    input  logic                   req_we,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_be,
    output logic                   mem_we,
    input  logic                   mem_rvalid,
    input  logic [31:0]            mem_rdata,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_data,
    output logic                   rsp_err,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned EntW = ADDR_W + 32 + 3 + 1;
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     count_q, count_d;
    logic [EntW-1:0]   fifo_q [DEPTH];
    logic [EntW-1:0]   iss_q, iss_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic              push, pop;
    logic [ADDR_W-1:0] iss_addr;
    logic [31:0]       iss_data;
    logic [2:0]        iss_type;
    logic              iss_we;
    logic              illegal, misalign, iss_err;
    logic [31:0]       lane, load_data, wdata_raw;
    logic [3:0]        be_raw;

    assign {iss_addr, iss_data, iss_type, iss_we} = iss_q;

    assign req_ready = (count_q < FullCnt);
    assign push      = req_valid && req_ready;
    // The head is popped into the issue register whenever the FSM is about to enter ISSUE.
    assign pop       = ((state_q == StIdle) || (state_q == StResp)) && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        iss_d    = iss_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            iss_d    = fifo_q[rd_ptr_q];
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {req_addr, req_data, req_type_m, req_we};
    end

    always_comb begin
        illegal = 1'b0;
        case (iss_type)
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            3'b100, 3'b101:         illegal = iss_we;
            default:                illegal = 1'b0;
        endcase
        misalign = ((iss_type[1:0] == 2'b01) && iss_addr[0]) ||
                   ((iss_type == 3'b010) && (iss_addr[1:0] != 2'b00));
        iss_err  = illegal || misalign;
    end

    always_comb begin
        lane = mem_rdata >> {iss_addr[1:0], 3'b000};
        case (iss_type)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_data = {24'b0, lane[7:0]};
            3'b101:  load_data = {16'b0, lane[15:0]};
            default: load_data = mem_rdata;
        endcase
        case (iss_type[1:0])
            2'b00: begin
                be_raw    = 4'b0001 << iss_addr[1:0];
                wdata_raw = {4{iss_data[7:0]}};
            end
            2'b01: begin
                be_raw    = 4'b0011 << iss_addr[1:0];
                wdata_raw = {2{iss_data[15:0]}};
            end
            default: begin
                be_raw    = 4'b1111;
                wdata_raw = iss_data;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            StIdle: begin
                if (count_q != '0) state_d = StIssue;
            end
            StIssue: begin
                if (iss_err) begin
                    state_d    = StResp;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                end else if (mem_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_rvalid) begin
                    state_d    = StResp;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = iss_we ? '0 : load_data;
                end
            end
            StResp: begin
                state_d = (count_q != '0) ? StIssue : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            iss_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            iss_q      <= iss_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign mem_valid = (state_q == StIssue) && !iss_err;
    assign mem_addr  = {iss_addr[ADDR_W-1:2], 2'b00};
    assign mem_be    = mem_valid ? be_raw : 4'b0000;
    assign mem_we    = mem_valid && iss_we;
    assign mem_wdata = (mem_valid && iss_we) ? wdata_raw : '0;
    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = rsp_valid ? rsp_data_q : '0;
    assign rsp_err   = rsp_valid && rsp_err_q;
    assign q_count   = count_q;

endmodule

// File: tb/tb_lsu_req_queue.sv
// Self-checking bench for lsu_req_queue: directed cases plus randomized streams checked
// against a transaction-level model of the bus command and the core response.
module tb_lsu_req_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [2:0]  req_type_m = '0;
    logic        req_we = 1'b0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [2:0]  q_count;

    lsu_req_queue #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_type_m (req_type_m),
        .req_we     (req_we),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_we     (mem_we),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .q_count    (q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  t;
        logic        w;
        logic [31:0] rdata;
    } req_t;

    req_t        pend[$];
    int          checks = 0;
    int          failures = 0;
    bit          bus_en = 1'b0;
    int          ready_pct = 100;
    int          max_delay = 0;
    bit          noise = 1'b0;
    bit          rv_pending = 1'b0;
    int          rv_wait = 0;
    logic [31:0] rv_data = '0;

    // Reference model of the access rules.
    function automatic logic exp_err(logic [31:0] a, logic [2:0] t, logic w);
        case (t)
            3'b000:  return 1'b0;
            3'b001:  return a[0];
            3'b010:  return (a % 4) != 0;
            3'b100:  return w;
            3'b101:  return w | a[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(logic [31:0] a, logic [2:0] t);
        int n;
        n = (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
        if (n == 4) return 4'hF;
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(logic [31:0] d, logic [2:0] t, logic w);
        if (!w) return 32'h0;
        case (t[1:0])
            2'b00:   return {24'b0, d[7:0]} * 32'h0101_0101;
            2'b01:   return {16'b0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_rsp(logic [31:0] rd, logic [31:0] a, logic [2:0] t,
                                            logic w);
        logic [31:0] v, b, h;
        if (w || exp_err(a, t, w)) return 32'h0;
        v = rd >> (8 * (a % 4));
        b = v & 32'hFF;
        h = v & 32'hFFFF;
        case (t)
            3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return rd;
        endcase
    endfunction

    // Bus slave: one read response per accepted command, optional delay and stray rvalid.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_en) begin
                mem_rvalid = 1'b0;
                if (rv_pending) begin
                    if (rv_wait == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rv_data;
                        rv_pending = 1'b0;
                    end else begin
                        rv_wait--;
                    end
                end else if (noise && $urandom_range(3) == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                end
                mem_ready = ($urandom_range(99) < ready_pct);
                if (mem_valid && mem_ready && !rv_pending) begin
                    rv_pending = 1'b1;
                    rv_data    = (pend.size() > 0) ? pend[0].rdata : 32'h0;
                    rv_wait    = $urandom_range(max_delay);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic do_single(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                             input logic w, input logic [31:0] rd,
                             output logic cmd_seen, output logic [31:0] c_addr,
                             output logic [31:0] c_wdata, output logic [3:0] c_be,
                             output logic c_we, output int pulses, output logic [31:0] r_data,
                             output logic r_err, output int lat);
        req_t r;
        cmd_seen = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
        pulses = 0; r_data = '0; r_err = 1'b0; lat = -1;
        ready_pct = 100; max_delay = 0; noise = 1'b0; rv_pending = 1'b0; bus_en = 1'b1;
        r.addr = a; r.data = d; r.t = t; r.w = w; r.rdata = rd;
        pend.push_back(r);
        @(negedge clk); #1;
        req_addr = a; req_data = d; req_type_m = t; req_we = w; req_valid = 1'b1;
        @(negedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) begin @(negedge clk); #1; end
            if (mem_valid && !cmd_seen) begin
                cmd_seen = 1'b1; c_addr = mem_addr; c_wdata = mem_wdata;
                c_be = mem_be; c_we = mem_we;
            end
            if (rsp_valid) begin
                if (pulses == 0) begin
                    r_data = rsp_data; r_err = rsp_err; lat = k - 1;
                end
                pulses++;
            end
        end
        pend.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); #1;
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        checks++; if (mem_be !== 4'h0) begin failures++; $display("FAIL reset_mem_be got=%b exp=0000", mem_be); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL reset_q_count got=%0d exp=0", q_count); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_load_byte();
        logic cs, cwe, re; logic [31:0] ca, cwd, rdat; logic [3:0] cbe; int p, lat;
        do_single(32'h103, 32'h0, 3'b000, 1'b0, 32'h80FF_1234, cs, ca, cwd, cbe, cwe, p, rdat, re, lat);
        checks++; if (cs !== 1'b1) begin failures++; $display("FAIL lb_cmd got=%b exp=1", cs); end
        checks++; if (ca !== 32'h100) begin failures++; $display("FAIL lb_mem_addr got=%h exp=100", ca); end
        checks++; if (cbe !== 4'b1000) begin failures++; $display("FAIL lb_mem_be got=%b exp=1000", cbe); end
        checks++; if (cwe !== 1'b0) begin failures++; $display("FAIL lb_mem_we got=%b exp=0", cwe); end
        checks++; if (p !== 1) begin failures++; $display("FAIL lb_rsp_pulses got=%0d exp=1", p); end
        checks++; if (rdat !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rsp_data got=%h exp=ffffff80", rdat); end
        checks++; if (re !== 1'b0) begin failures++; $display("FAIL lb_rsp_err got=%b exp=0", re); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL lb_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_store_half();
        logic cs, cwe, re; logic [31:0] ca, cwd, rdat; logic [3:0] cbe; int p, lat;
        do_single(32'h202, 32'h0000_BEEF, 3'b001, 1'b1, 32'h1234_5678, cs, ca, cwd, cbe, cwe, p, rdat, re, lat);
        checks++; if (ca !== 32'h200) begin failures++; $display("FAIL sh_mem_addr got=%h exp=200", ca); end
        checks++; if (cbe !== 4'b1100) begin failures++; $display("FAIL sh_mem_be got=%b exp=1100", cbe); end
        checks++; if (cwd !== 32'hBEEF_BEEF) begin failures++; $display("FAIL sh_mem_wdata got=%h exp=beefbeef", cwd); end
        checks++; if (cwe !== 1'b1) begin failures++; $display("FAIL sh_mem_we got=%b exp=1", cwe); end
        checks++; if (p !== 1) begin failures++; $display("FAIL sh_rsp_pulses got=%0d exp=1", p); end
        checks++; if (rdat !== 32'h0) begin failures++; $display("FAIL sh_rsp_data got=%h exp=0", rdat); end
        checks++; if (re !== 1'b0) begin failures++; $display("FAIL sh_rsp_err got=%b exp=0", re); end
    endtask

    task automatic test_misaligned();
        logic cs, cwe, re; logic [31:0] ca, cwd, rdat; logic [3:0] cbe; int p, lat;
        logic [31:0] addrs [3];
        logic [2:0]  types [3];
        logic        wes   [3];
        addrs[0] = 32'h101; types[0] = 3'b010; wes[0] = 1'b0;  // misaligned LW
        addrs[1] = 32'h104; types[1] = 3'b100; wes[1] = 1'b1;  // store with BU
        addrs[2] = 32'h108; types[2] = 3'b011; wes[2] = 1'b0;  // reserved type
        for (int i = 0; i < 3; i++) begin
            do_single(addrs[i], 32'hDEAD_BEEF, types[i], wes[i], 32'hFFFF_FFFF,
                      cs, ca, cwd, cbe, cwe, p, rdat, re, lat);
            checks++; if (cs !== 1'b0) begin failures++; $display("FAIL err%0d_no_cmd got=%b exp=0", i, cs); end
            checks++; if (p !== 1) begin failures++; $display("FAIL err%0d_rsp_pulses got=%0d exp=1", i, p); end
            checks++; if (re !== 1'b1) begin failures++; $display("FAIL err%0d_rsp_err got=%b exp=1", i, re); end
            checks++; if (rdat !== 32'h0) begin failures++; $display("FAIL err%0d_rsp_data got=%h exp=0", i, rdat); end
        end
    endtask

    task automatic test_full();
        req_t r; int got; logic [31:0] ed;
        bus_en = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        pend.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL full_ready_before_push%0d got=%b exp=1", i, req_ready); end
            r.addr = 32'h1000 + 32'(i * 4); r.data = 32'h0; r.t = 3'b010; r.w = 1'b0;
            r.rdata = $urandom;
            pend.push_back(r);
            req_addr = r.addr; req_data = r.data; req_type_m = r.t; req_we = r.w;
            req_valid = 1'b1;
        end
        @(negedge clk); #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL full_req_ready got=%b exp=0", req_ready); end
        checks++; if (q_count !== 3'd4) begin failures++; $display("FAIL full_q_count got=%0d exp=4", q_count); end
        checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL full_mem_valid_stall got=%b exp=1", mem_valid); end
        checks++; if (mem_addr !== 32'h1000) begin failures++; $display("FAIL full_mem_addr_stall got=%h exp=1000", mem_addr); end
        ready_pct = 100; max_delay = 0; noise = 1'b0; rv_pending = 1'b0; bus_en = 1'b1;
        got = 0;
        for (int c = 0; c < 100 && got < 5; c++) begin
            @(negedge clk); #1;
            if (rsp_valid) begin
                ed = exp_rsp(pend[0].rdata, pend[0].addr, pend[0].t, pend[0].w);
                checks++; if (rsp_data !== ed) begin failures++; $display("FAIL full_rsp%0d_data got=%h exp=%h", got, rsp_data, ed); end
                pend.pop_front();
                got++;
            end
        end
        checks++; if (got !== 5) begin failures++; $display("FAIL full_rsp_count got=%0d exp=5", got); end
        pend.delete();
    endtask

    task automatic test_random_stream(input int n_req, input bit zext_only, input int rpct,
                                      input int dly, input bit nz);
        int sent, got, cyc; bit prev_v, prev_r;
        req_t r; logic [31:0] ed, ea; logic ee;
        sent = 0; got = 0; cyc = 0; prev_v = 1'b0; prev_r = 1'b0;
        pend.delete();
        ready_pct = rpct; max_delay = dly; noise = nz; rv_pending = 1'b0; bus_en = 1'b1;
        while (got < n_req && cyc < 4000) begin
            @(negedge clk); #1;
            cyc++;
            if (prev_v && !prev_r) begin
                checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL rnd_mem_valid_drop got=%b exp=1", mem_valid); end
            end
            if (mem_valid) begin
                checks++;
                if (pend.size() == 0 || exp_err(pend[0].addr, pend[0].t, pend[0].w)) begin
                    failures++; $display("FAIL rnd_unexpected_cmd got=1 exp=0");
                end else begin
                    ea = pend[0].addr & 32'hFFFF_FFFC;
                    checks++; if (mem_addr !== ea) begin failures++; $display("FAIL rnd_mem_addr got=%h exp=%h", mem_addr, ea); end
                    checks++; if (mem_be !== exp_be(pend[0].addr, pend[0].t)) begin failures++; $display("FAIL rnd_mem_be got=%b exp=%b", mem_be, exp_be(pend[0].addr, pend[0].t)); end
                    ed = exp_wdata(pend[0].data, pend[0].t, pend[0].w);
                    checks++; if (mem_wdata !== ed) begin failures++; $display("FAIL rnd_mem_wdata got=%h exp=%h", mem_wdata, ed); end
                    checks++; if (mem_we !== pend[0].w) begin failures++; $display("FAIL rnd_mem_we got=%b exp=%b", mem_we, pend[0].w); end
                end
            end
            prev_v = mem_valid; prev_r = mem_ready;
            checks++; if (req_ready !== (q_count < DEPTH)) begin failures++; $display("FAIL rnd_req_ready got=%b count=%0d", req_ready, q_count); end
            if (rsp_valid) begin
                checks++;
                if (pend.size() == 0) begin
                    failures++; $display("FAIL rnd_extra_rsp got=1 exp=0");
                end else begin
                    ee = exp_err(pend[0].addr, pend[0].t, pend[0].w);
                    ed = exp_rsp(pend[0].rdata, pend[0].addr, pend[0].t, pend[0].w);
                    if (rsp_err !== ee) begin failures++; $display("FAIL rnd_rsp%0d_err got=%b exp=%b", got, rsp_err, ee); end
                    checks++; if (rsp_data !== ed) begin failures++; $display("FAIL rnd_rsp%0d_data got=%h exp=%h", got, rsp_data, ed); end
                    pend.pop_front();
                end
                got++;
            end
            if (sent < n_req && (zext_only || $urandom_range(3) != 0)) begin
                if (zext_only) begin
                    r.t = ($urandom_range(1) == 1) ? 3'b100 : 3'b101;
                    r.addr = $urandom;
                    if (r.t == 3'b101) r.addr[0] = 1'b0;
                    r.w = 1'b0;
                end else if ($urandom_range(3) != 0) begin
                    case ($urandom_range(4))
                        0: r.t = 3'b000;
                        1: r.t = 3'b001;
                        2: r.t = 3'b010;
                        3: r.t = 3'b100;
                        default: r.t = 3'b101;
                    endcase
                    r.addr = $urandom;
                    if (r.t[1:0] == 2'b01) r.addr[0] = 1'b0;
                    if (r.t == 3'b010) r.addr[1:0] = 2'b00;
                    r.w = r.t[2] ? 1'b0 : 1'($urandom_range(1));
                end else begin
                    r.t = 3'($urandom_range(7));
                    r.addr = $urandom;
                    r.w = 1'($urandom_range(1));
                end
                r.data = $urandom; r.rdata = $urandom;
                req_addr = r.addr; req_data = r.data; req_type_m = r.t; req_we = r.w;
                req_valid = 1'b1;
                if (req_ready) begin
                    pend.push_back(r);
                    sent++;
                end
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        checks++; if (got !== n_req) begin failures++; $display("FAIL rnd_rsp_count got=%0d exp=%0d", got, n_req); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL rnd_drain_q_count got=%0d exp=0", q_count); end
        checks++; if (pend.size() !== 0) begin failures++; $display("FAIL rnd_lost_rsp got=%0d exp=0", pend.size()); end
        pend.delete();
    endtask

    task automatic test_reset_mid();
        int bad;
        bus_en = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; rv_pending = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            req_addr = 32'h400 + 32'(i * 4); req_data = '0; req_type_m = 3'b010;
            req_we = 1'b0; req_valid = 1'b1;
        end
        @(negedge clk); #1;
        req_valid = 1'b0;
        checks++; if (mem_valid !== 1'b1) begin failures++; $display("FAIL rmid_stalled_cmd got=%b exp=1", mem_valid); end
        mem_ready = 1'b1;
        @(negedge clk); #1;
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rmid_mem_valid got=%b exp=0", mem_valid); end
        checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL rmid_q_count got=%0d exp=0", q_count); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_rsp_valid got=%b exp=0", rsp_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rmid_req_ready got=%b exp=1", req_ready); end
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk); #1;
        mem_rvalid = 1'b0;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (rsp_valid || mem_valid) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rmid_activity_after_reset got=%0d exp=0", bad); end
        pend.delete();
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_full();
        test_random_stream(3 * DEPTH, 1'b1, 100, 0, 1'b0);
        test_random_stream(80, 1'b0, 60, 2, 1'b1);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_req_queue.md
LSU_REQ_QUEUE -- requirements
Module: lsu_req_queue

Interface
REQ-001 Parameter DEPTH, default 4, request queue entries; SHALL be a power of two >= 2.
REQ-002 Parameter ADDR_W, default 32, byte-address width; data width SHALL be fixed at 32.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 req_valid/req_ready  in/out  1/1  core request handshake.
REQ-006 req_addr  in  ADDR_W  byte address; req_data  in  32  store data, LSB-aligned.
REQ-007 req_type_m  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU; req_we  in  1  store when 1.
REQ-008 mem_valid/mem_ready  out/in  1/1  bus command handshake.
REQ-009 mem_addr  out  ADDR_W  word-aligned address, bits[1:0]=0; mem_wdata  out  32; mem_be  out  4; mem_we  out  1.
REQ-010 mem_rvalid  in  1, mem_rdata  in  32  bus response, one per accepted command.
REQ-011 rsp_valid  out  1, rsp_data  out  32, rsp_err  out  1  core response, one-cycle pulse per request.
REQ-012 q_count  out  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-013 Queue SHALL be a circular FIFO storing {addr, data, type_m, we}; req_ready = (q_count < DEPTH).
REQ-014 Request accepted when req_valid && req_ready; simultaneous push and pop SHALL leave q_count unchanged.
REQ-015 Pointers SHALL wrap modulo DEPTH with no bubble at wrap.
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP; at most one bus command outstanding.
REQ-017 IDLE -> ISSUE when queue non-empty; head entry popped on entering ISSUE and held in an issue register.
REQ-018 In ISSUE, misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0) or illegal type_m (011, 110, 111, or store with 100/101) SHALL go to RESP with rsp_err=1, rsp_data=0, and no bus command.
REQ-019 Legal ISSUE asserts mem_valid; mem_valid and all mem_* SHALL stay stable until mem_ready; on mem_ready -> WAIT.
REQ-020 mem_be: B -> 0001<<addr[1:0]; H -> 0011<<addr[1:0]; W -> 1111; mem_we = we.
REQ-021 mem_wdata = store data replicated across lanes (B: 4x byte, H: 2x half, W: as is); 0 for loads.
REQ-022 WAIT -> RESP on mem_rvalid; mem_rvalid outside WAIT SHALL be ignored.
REQ-023 Load data: select lane by addr[1:0], sign-extend for B/H, zero-extend for BU/HU; stores return rsp_data=0.
REQ-024 RESP drives rsp_valid=1 for exactly one cycle, then -> ISSUE if queue non-empty else IDLE.
REQ-025 Response order SHALL equal request acceptance order; minimum latency accept->rsp_valid = 3 cycles with mem_ready and mem_rvalid both immediate.
REQ-026 Core has no rsp backpressure; responses SHALL never be dropped.

Reset
REQ-027 On rst_n low: FSM=IDLE, pointers=0, q_count=0, mem_valid=0, rsp_valid=0, rsp_err=0, rsp_data=0, mem_be=0, mem_we=0.
REQ-028 Reset mid-transaction SHALL discard queue and outstanding command; no response emitted after reset.
REQ-029 req_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-030 LB addr 0x103, mem_rdata 0x80FF_1234 -> mem_be=1000, rsp_data=0xFFFF_FF80, rsp_err=0.
REQ-031 SH addr 0x202, data 0x0000_BEEF -> mem_addr=0x200, mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, rsp_data=0.
REQ-032 LW addr 0x101 -> no mem_valid, rsp_valid one cycle with rsp_err=1, rsp_data=0.
REQ-033 DEPTH=4, mem_ready held 0, push 5 requests -> req_ready=0 after 4th is queued beyond issue register, q_count=4; release -> 5 responses in order.
REQ-034 Continuous push/pop over 3xDEPTH requests -> pointer wrap, no loss, in-order LHU/LBU zero-extended data.
REQ-035 rst_n low during WAIT -> mem_valid=0, q_count=0, no rsp_valid after release despite late mem_rvalid.
